// File: rtl/text_mem_pkg.sv
// Shared types and default sizes for the Braille text store and its loader.
package text_mem_pkg;

  localparam int unsigned TEXT_DEPTH = 256;
  localparam int unsigned TEXT_AW    = 8;
  localparam int unsigned TEXT_DW    = 8;

  localparam logic [7:0] NUL = 8'h00;

  typedef enum logic [1:0] {
    StClear,
    StLoad,
    StPad,
    StDone
  } state_t;

endpackage

// File: rtl/text_mem_ram.sv
// DEPTH x DW text store: one synchronous write port, one combinational read port.
module text_mem_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // No reset on the array; the loader zeroes it by walking every address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/text_mem_loader.sv
// Loads an ASCII byte stream into the text store, null-pads the tail and flags the text valid.
module text_mem_loader
  import text_mem_pkg::*;
#(
  parameter int unsigned DEPTH = TEXT_DEPTH,
  parameter int unsigned AW    = TEXT_AW,
  parameter int unsigned DW    = TEXT_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  input  logic          restart,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          text_valid,
  output logic [AW-1:0] text_len,
  output logic          overflow
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] ptr_inc;
  logic          we;
  logic [DW-1:0] wdata;
  logic          xfer;
  logic          is_nul;

  assign ptr_inc = wr_ptr + 1'b1;
  assign xfer    = in_valid && in_ready;
  assign is_nul  = (in_data == DW'(NUL));

  always_comb begin
    we    = 1'b0;
    wdata = '0;
    unique case (state)
      StClear, StPad: we = 1'b1;
      StLoad: begin
        we    = xfer && !is_nul;
        wdata = in_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= StClear;
      wr_ptr     <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b1;
      text_valid <= 1'b0;
      text_len   <= '0;
      overflow   <= 1'b0;
    end else begin
      unique case (state)
        StClear: begin
          wr_ptr <= ptr_inc;
          if (wr_ptr == LAST) begin
            state    <= StLoad;
            wr_ptr   <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        StLoad: begin
          if (xfer) begin
            if (is_nul) begin
              state    <= StPad;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              wr_ptr   <= ptr_inc;
              text_len <= text_len + 1'b1;
              // The last word is reserved so the text is always NUL-terminated.
              if (in_last || ptr_inc == LAST) begin
                state    <= StPad;
                in_ready <= 1'b0;
                busy     <= 1'b1;
                overflow <= !in_last;
              end
            end
          end
        end
        StPad: begin
          wr_ptr <= ptr_inc;
          if (wr_ptr == LAST) begin
            state      <= StDone;
            busy       <= 1'b0;
            text_valid <= 1'b1;
          end
        end
        StDone: begin
          if (restart) begin
            state      <= StClear;
            wr_ptr     <= '0;
            text_len   <= '0;
            overflow   <= 1'b0;
            text_valid <= 1'b0;
            busy       <= 1'b1;
          end
        end
        default: state <= StClear;
      endcase
    end
  end

  text_mem_ram #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(wdata),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_text_mem_loader.sv
// Scoreboard bench for text_mem_loader: expected store image queued as bytes are driven.
module tb_text_mem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       restart = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic       in_ready;
  logic [7:0] rd_data;
  logic       busy;
  logic       text_valid;
  logic [7:0] text_len;
  logic       overflow;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  text_mem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .restart   (restart),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .text_valid(text_valid),
    .text_len  (text_len),
    .overflow  (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the byte until it is taken or the budget runs out.
  task automatic send_byte(input logic [7:0] d, input logic last, input int budget,
                           output bit acc);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    acc      = 1'b0;
    for (int i = 0; i < budget && !acc; i++) begin
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_ready(output int n, output bit busy_ok);
    n       = 0;
    busy_ok = 1'b1;
    while (!in_ready && n < 400) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      step();
      n++;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (text_valid !== 1'b1 && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic push_pad(input int from);
    for (int a = from; a < 256; a++) sb.push_back(exp_t'{addr: 8'(a), data: 8'h00});
  endtask

  task automatic readback(input string name);
    exp_t e;
    while (sb.size() > 0) begin
      e       = sb.pop_front();
      rd_addr = e.addr;
      @(negedge clk);
      checks++;
      if (rd_data !== e.data) begin
        errors++;
        $display("FAIL %s mem[%0d]: got %h expected %h", name, e.addr, rd_data, e.data);
      end
    end
    step();
  endtask

  task automatic test_reset();
    int n;
    bit bok;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset busy: got %b expected 1", busy); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b expected 0", in_ready); end
    if (text_valid !== 1'b0) begin errors++; $display("FAIL reset text_valid: got %b expected 0", text_valid); end
    if (text_len !== 8'd0) begin errors++; $display("FAIL reset text_len: got %0d expected 0", text_len); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b expected 0", overflow); end
    reset = 1'b1;
    wait_ready(n, bok);
    checks += 2;
    if (n != 256) begin errors++; $display("FAIL clear_len: got %0d cycles expected 256", n); end
    if (!bok) begin errors++; $display("FAIL clear_busy: got busy low during clear expected high"); end
    push_pad(0);
    readback("clear_image");
  endtask

  task automatic restart_to_load(input string name);
    int n;
    bit bok;
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks += 4;
    if (text_valid !== 1'b0) begin errors++; $display("FAIL %s text_valid: got %b expected 0", name, text_valid); end
    if (text_len !== 8'd0) begin errors++; $display("FAIL %s text_len: got %0d expected 0", name, text_len); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL %s overflow: got %b expected 0", name, overflow); end
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b expected 1", name, busy); end
    wait_ready(n, bok);
    checks++;
    if (n != 256 || !bok) begin
      errors++;
      $display("FAIL %s clear_len: got %0d cycles busy_ok=%b expected 256 busy_ok=1", name, n, bok);
    end
  endtask

  task automatic test_text();
    string s = "Text to Braille";
    bit    acc;
    int    n;
    for (int i = 0; i < 15; i++) begin
      if (i % 3 == 2) step();
      send_byte(s[i], (i == 14), 10, acc);
      sb.push_back(exp_t'{addr: 8'(i), data: s[i]});
      checks++;
      if (!acc) begin errors++; $display("FAIL text_accept byte %0d: got no transfer expected transfer", i); end
    end
    push_pad(15);
    checks += 2;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL text_pad_state: got busy=%b in_ready=%b expected 1 0", busy, in_ready);
    end
    wait_valid(n);
    if (n != 241) begin errors++; $display("FAIL text_pad_len: got %0d expected 241", n); end
    checks += 3;
    if (text_len !== 8'd15) begin errors++; $display("FAIL text_len: got %0d expected 15", text_len); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL text_overflow: got %b expected 0", overflow); end
    if (busy !== 1'b0) begin errors++; $display("FAIL text_done_busy: got %b expected 0", busy); end
    readback("text_image");
  endtask

  task automatic test_null_term();
    logic [7:0] msg[3] = '{8'h48, 8'h69, 8'h00};
    bit         acc;
    int         n;
    restart_to_load("null_restart");
    for (int i = 0; i < 3; i++) begin
      send_byte(msg[i], 1'b0, 10, acc);
      checks++;
      if (!acc) begin errors++; $display("FAIL null_accept byte %0d: got no transfer expected transfer", i); end
    end
    sb.push_back(exp_t'{addr: 8'd0, data: 8'h48});
    sb.push_back(exp_t'{addr: 8'd1, data: 8'h69});
    push_pad(2);
    wait_valid(n);
    checks += 3;
    if (n != 254) begin errors++; $display("FAIL null_pad_len: got %0d expected 254", n); end
    if (text_len !== 8'd2) begin errors++; $display("FAIL null_text_len: got %0d expected 2", text_len); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL null_overflow: got %b expected 0", overflow); end
    readback("null_image");
  endtask

  task automatic test_overflow();
    bit acc;
    int n;
    int cnt = 0;
    restart_to_load("ovf_restart");
    for (int i = 0; i < 300; i++) begin
      if (!in_ready) break;
      send_byte(8'h41, 1'b0, 4, acc);
      if (!acc) break;
      sb.push_back(exp_t'{addr: 8'(cnt), data: 8'h41});
      cnt++;
    end
    push_pad(cnt);
    checks += 4;
    if (cnt != 255) begin errors++; $display("FAIL ovf_count: got %0d expected 255", cnt); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_in_ready: got %b expected 0", in_ready); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    if (text_len !== 8'd255) begin errors++; $display("FAIL ovf_text_len: got %0d expected 255", text_len); end
    wait_valid(n);
    checks++;
    if (n != 1) begin errors++; $display("FAIL ovf_pad_len: got %0d expected 1", n); end
    readback("ovf_image");
  endtask

  task automatic test_restart();
    bit acc;
    int n;
    restart_to_load("rst_restart");
    restart = 1'b1;
    step();
    restart = 1'b0;
    repeat (2) step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || text_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_in_load: got in_ready=%b busy=%b text_valid=%b expected 1 0 0",
               in_ready, busy, text_valid);
    end
    send_byte(8'h41, 1'b1, 10, acc);
    sb.push_back(exp_t'{addr: 8'd0, data: 8'h41});
    push_pad(1);
    wait_valid(n);
    checks += 3;
    if (!acc) begin errors++; $display("FAIL restart_accept: got no transfer expected transfer"); end
    if (n != 255) begin errors++; $display("FAIL restart_pad_len: got %0d expected 255", n); end
    if (text_len !== 8'd1) begin errors++; $display("FAIL restart_text_len: got %0d expected 1", text_len); end
    readback("restart_image");
  endtask

  task automatic test_reset_mid_pad();
    bit acc;
    int n;
    bit bok;
    restart_to_load("mid_restart");
    send_byte(8'h48, 1'b0, 10, acc);
    send_byte(8'h69, 1'b1, 10, acc);
    repeat (10) step();
    checks++;
    if (text_len !== 8'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pad_state: got text_len=%0d busy=%b expected 2 1", text_len, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks += 4;
    if (text_len !== 8'd0) begin errors++; $display("FAIL mid_text_len: got %0d expected 0", text_len); end
    if (text_valid !== 1'b0) begin errors++; $display("FAIL mid_text_valid: got %b expected 0", text_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %b expected 0", in_ready); end
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    wait_ready(n, bok);
    checks++;
    if (n != 256 || !bok) begin
      errors++;
      $display("FAIL mid_clear_len: got %0d cycles busy_ok=%b expected 256 busy_ok=1", n, bok);
    end
    push_pad(0);
    readback("mid_image");
  endtask

  initial begin
    test_reset();
    test_text();
    test_null_term();
    test_overflow();
    test_restart();
    test_reset_mid_pad();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

endmodule

// File: doc/text_mem_loader.md
Name: text_mem_loader

Overview:
Writer side of the Braille text memory: accepts an ASCII byte stream over a valid/ready handshake and writes it sequentially into an internal 256x8 text store. It then null-pads the remainder and flags the text as valid. Its combinational read port serves size_calculator and braille_converter unchanged, so the text is loaded at run time instead of being fixed at reset.

Parameters:
DEPTH, 256, number of 8-bit words in the text store (power of two)
AW, 8, address width, log2(DEPTH)
DW, 8, data width (ASCII byte)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  producer has a byte on in_data
in_data  input  8  ASCII byte; 0x00 = terminator
in_last  input  1  marks final byte of the message (qualified by in_valid)
in_ready  output  1  loader can accept a byte this cycle
restart  input  1  single-cycle pulse: discard text, start a new load
rd_addr  input  8  read address from downstream consumers
rd_data  output  8  mem[rd_addr], combinational
busy  output  1  high in CLEAR and PAD
text_valid  output  1  store holds a complete, null-padded message
text_len  output  8  count of non-null characters stored (0..DEPTH-1)
overflow  output  1  sticky: message was truncated at DEPTH-1 characters

Behaviour:
- Reset (reset=0, async): state=CLEAR, wr_ptr=0, in_ready=0, busy=1, text_valid=0, text_len=0, overflow=0. Memory contents are not reset asynchronously; CLEAR zeroes them.
- CLEAR: writes 0x00 to wr_ptr each cycle, addresses 0..DEPTH-1 on the first DEPTH edges after reset release. Then wr_ptr=0 and state goes to LOAD. in_ready=0 throughout.
- LOAD: in_ready=1, busy=0. A transfer occurs on a rising edge with in_valid & in_ready.
  - Byte != 0x00: written to mem[wr_ptr]; wr_ptr and text_len increment.
  - Byte == 0x00: not written, counters unchanged; go to PAD.
  - in_last=1 with a non-null byte: byte is stored, then go to PAD.
  - Capacity is DEPTH-1 characters, so mem[DEPTH-1] is always 0x00. When the transfer that makes wr_ptr=DEPTH-1 is accepted without in_last, set overflow=1 and go to PAD.
  - in_valid=0 cycles (gaps) are allowed; nothing changes.
- PAD: in_ready=0, busy=1. Writes 0x00 at wr_ptr..DEPTH-1, one word per cycle, so PAD lasts DEPTH-text_len cycles. After the last pad write, go to DONE.
- Timing: the terminating transfer is at edge E; text_valid rises after edge E+(DEPTH-text_len).
- DONE: text_valid=1, in_ready=0, busy=0. text_len and overflow are held.
- restart:
  - Sampled only in DONE. Goes to CLEAR with wr_ptr=0, text_len=0, overflow=0, text_valid=0 on the next edge.
  - Ignored in all other states.
- Read port:
  - rd_data=mem[rd_addr] combinationally in every state.
  - A write to address A at edge N is visible on rd_data from edge N onward.
  - Consumers must qualify reads with text_valid.
- Reset mid-load or mid-pad: async return to CLEAR; all outputs take their reset values immediately.
- No stall is possible inside CLEAR/PAD; in_valid during those states is ignored (no transfer).

Decomposition:
- Package text_mem_pkg: state enum {CLEAR, LOAD, PAD, DONE}, DEPTH/AW/DW defaults, NUL=8'h00.
- Sub-module text_mem_ram: DEPTH x DW array, one synchronous write port (we, waddr, wdata), one combinational read port. It is instantiated once.
- The FSM, pointer and counter stay in text_mem_loader.

Test Plan:
- Release reset, hold in_valid=0 -> busy=1 and in_ready=0 for exactly 256 cycles, then in_ready=1. All 256 reads return 0x00.
- Stream "Text to Braille" (0x54 0x65 … 0x65, 15 bytes), in_last on byte 15, valid gaps every 3rd cycle -> text_len=15, mem[0]=0x54, mem[8]=0x42, mem[14]=0x65, mem[15..255]=0x00. text_valid rises 241 cycles after the last transfer.
- Send 0x48 0x69 0x00 -> text_len=2, mem[2]=0x00, overflow=0, text_valid after 254 pad cycles.
- Send 300 bytes of 0x41, no in_last -> exactly 255 transfers accepted, then in_ready=0. overflow=1, text_len=255, mem[254]=0x41, mem[255]=0x00, PAD lasts 1 cycle.
- In DONE, pulse restart, then load 0x41 with in_last -> CLEAR runs 256 cycles, overflow/text_len cleared. Final text_len=1, mem[1]=0x00. A restart pulsed during LOAD has no effect.
- Assert reset during PAD (e.g. 10 cycles after terminator) -> text_valid, in_ready, busy, text_len take their reset values immediately. A full CLEAR follows release.
